// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and frame types for the fft8 datapath
package fft_pkg;

  localparam int DATA_W    = 32;
  localparam int NPTS      = 8;
  localparam int NPTS_LOG2 = $clog2(NPTS);

  typedef logic [DATA_W-1:0]     sample_t;
  typedef sample_t [NPTS-1:0]    frame_t;

endpackage

// File: rtl/frame_bank.sv
// rtl/frame_bank.sv - one NPTS x DATA_W register bank, slot write port, parallel read-out
module frame_bank #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int NPTS   = fft_pkg::NPTS,
  parameter int SLOT_W = $clog2(NPTS)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [SLOT_W-1:0]        slot_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [NPTS*DATA_W-1:0]   frame_o
);
  import fft_pkg::*;

  // Contents are don't-care after reset, so the storage carries no reset.
  logic [DATA_W-1:0] mem_q [NPTS];

  // Write the addressed slot when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[slot_i] <= data_i;
    end
  end

  // Slot k lands on bits [k*DATA_W +: DATA_W] so it lines up with core input Ak.
  for (genvar k = 0; k < NPTS; k++) begin : g_slot
    assign frame_o[k*DATA_W +: DATA_W] = mem_q[k];
  end

endmodule

// File: rtl/fft8_frame_loader.sv
// rtl/fft8_frame_loader.sv - stream-to-frame ping-pong loader; optional FFT8_LOADER_LAST_CHECK_EN
module fft8_frame_loader #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int NPTS   = fft_pkg::NPTS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     f_valid,
  input  logic                     f_ready,
  output logic [NPTS*DATA_W-1:0]   f_data,
  output logic                     err
);
  import fft_pkg::*;

  localparam int CNT_W = $clog2(NPTS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NPTS - 1);

  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic                    wr_sel_q, wr_sel_d;
  logic                    rd_sel_q, rd_sel_d;
  logic [1:0]              full_q, full_d;
  logic                    err_q, err_d;

  logic                    s_acc;
  logic                    f_acc;
  logic                    last_slot;
  logic                    commit;
  logic                    discard;
  logic [NPTS*DATA_W-1:0]  bank_data [2];

  assign s_ready   = !full_q[wr_sel_q];
  assign f_valid   = full_q[rd_sel_q];
  assign f_data    = bank_data[rd_sel_q];
  assign err       = err_q;

  assign s_acc     = s_valid && s_ready;
  assign f_acc     = f_valid && f_ready;
  assign last_slot = (wr_cnt_q == LAST_SLOT);

  // A bank only receives writes while it is the write target, which is never while full.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .DATA_W (DATA_W),
      .NPTS   (NPTS),
      .SLOT_W (CNT_W)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (s_acc && (wr_sel_q == 1'(b))),
      .slot_i  (wr_cnt_q),
      .data_i  (s_data),
      .frame_o (bank_data[b])
    );
  end

`ifdef FFT8_LOADER_LAST_CHECK_EN
  // Early s_last throws the partial frame away; a missing s_last still commits by count.
  always_comb begin
    discard = s_acc && s_last && !last_slot;
    err_d   = s_acc && (s_last != last_slot);
    commit  = s_acc && last_slot;
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;

  // Framing is purely by count; s_last plays no part.
  always_comb begin
    discard = 1'b0;
    err_d   = 1'b0;
    commit  = s_acc && last_slot;
  end
`endif

  // Pointer, counter and full-flag updates; fill of one bank and drain of the other may coincide.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;

    if (s_acc) begin
      wr_cnt_d = discard ? '0 : wr_cnt_q + 1'b1;
    end

    if (commit) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end

    // A frame accept requires full[rd_sel] while a commit requires !full[wr_sel],
    // so the two never target the same bank in one cycle.
    if (f_acc) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
  end

  // Control state register; reset drops any partial or pending frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// tb/tb_fft8_frame_loader.sv - directed self-checking bench for fft8_frame_loader
module tb_fft8_frame_loader;

  localparam int DW = 32;
  localparam int NP = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              s_last;
  logic              f_valid;
  logic              f_ready;
  logic [NP*DW-1:0]  f_data;
  logic              err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft8_frame_loader #(.DATA_W(DW), .NPTS(NP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .f_data  (f_data),
    .err     (err)
  );

  function automatic logic [NP*DW-1:0] pack_seq(input logic [DW-1:0] base);
    logic [NP*DW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; f_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got=%b exp=0", f_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_frame_order();
    f_ready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = DW'(i + 1); s_last = (i == NP - 1);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL order_s_ready[%0d] got=%b exp=1", i, s_ready); end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL order_early_f_valid[%0d] got=%b exp=0", i, f_valid); end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL order_f_valid got=%b exp=1", f_valid); end
    checks++; if (f_data !== pack_seq(32'h1)) begin errors++; $display("FAIL order_f_data got=%h exp=%h", f_data, pack_seq(32'h1)); end
    @(negedge clk);
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL order_consumed got=%b exp=0", f_valid); end
  endtask

  task automatic test_backpressure();
    int n;
    int cyc;
    logic acc;
    do_reset();
    f_ready = 1'b0;
    n = 0; cyc = 0;
    while (n < 16 && cyc < 40) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = DW'(n + 1); s_last = (n % 8 == 7);
      acc = s_ready;
      @(posedge clk);
      if (acc) n++;
      cyc++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL bp_accepted got=%0d exp=16", n); end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL bp_cycles got=%0d exp=16", cyc); end
    @(negedge clk);
    s_data = DW'(17); s_last = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_s_ready got=%b exp=0", s_ready); end
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL bp_f_valid got=%b exp=1", f_valid); end
    checks++; if (f_data !== pack_seq(32'h1)) begin errors++; $display("FAIL bp_frame0 got=%h exp=%h", f_data, pack_seq(32'h1)); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_s_ready[%0d] got=%b exp=0", i, s_ready); end
      checks++; if (f_data !== pack_seq(32'h1)) begin errors++; $display("FAIL bp_hold_f_data[%0d] got=%h exp=%h", i, f_data, pack_seq(32'h1)); end
    end
    @(negedge clk);
    f_ready = 1'b1;
    @(negedge clk);
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL bp_frame1_valid got=%b exp=1", f_valid); end
    checks++; if (f_data !== pack_seq(32'h9)) begin errors++; $display("FAIL bp_frame1 got=%h exp=%h", f_data, pack_seq(32'h9)); end
    for (int k = 0; k < NP; k++) begin
      if (k > 0) @(negedge clk);
      s_valid = 1'b1; s_data = DW'(17 + k); s_last = (k == NP - 1);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_s_ready[%0d] got=%b exp=1", k, s_ready); end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL bp_frame2_valid got=%b exp=1", f_valid); end
    checks++; if (f_data !== pack_seq(32'd17)) begin errors++; $display("FAIL bp_frame2 got=%h exp=%h", f_data, pack_seq(32'd17)); end
    @(negedge clk);
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", f_valid); end
  endtask

  task automatic test_sustained();
    int frames;
    logic exp_v;
    do_reset();
    f_ready = 1'b1;
    frames = 0;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (k < 64) begin
        s_valid = 1'b1; s_data = 32'h1000_0000 + DW'(k); s_last = (k % 8 == 7);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL sus_s_ready[%0d] got=%b exp=1", k, s_ready); end
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      exp_v = (k > 0) && (k % 8 == 0);
      checks++; if (f_valid !== exp_v) begin errors++; $display("FAIL sus_f_valid[%0d] got=%b exp=%b", k, f_valid, exp_v); end
      if (f_valid === 1'b1) begin
        frames++;
        checks++;
        if (f_data !== pack_seq(32'h1000_0000 + DW'(k - 8))) begin
          errors++; $display("FAIL sus_frame[%0d] got=%h exp=%h", k, f_data, pack_seq(32'h1000_0000 + DW'(k - 8)));
        end
      end
    end
    checks++; if (frames !== 8) begin errors++; $display("FAIL sus_frame_count got=%0d exp=8", frames); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    f_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = (k < 8) ? 32'h40 + DW'(k) : 32'h50 + DW'(k - 8); s_last = (k == 7);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending got=%b exp=1", f_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rmid_f_valid got=%b exp=0", f_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_s_ready got=%b exp=1", s_ready); end
    f_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'hA0 + DW'(k); s_last = (k == NP - 1);
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rmid_residue[%0d] got=%b exp=0", k, f_valid); end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL rmid_frame_valid got=%b exp=1", f_valid); end
    checks++; if (f_data !== pack_seq(32'hA0)) begin errors++; $display("FAIL rmid_frame got=%h exp=%h", f_data, pack_seq(32'hA0)); end
    @(negedge clk);
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rmid_single_frame got=%b exp=0", f_valid); end
  endtask

  task automatic test_framing_error();
    int err_k;
    int frame_k;
    logic [DW-1:0] frame_base;
`ifdef FFT8_LOADER_LAST_CHECK_EN
    err_k = 3; frame_k = 11; frame_base = 32'hC3;
`else
    err_k = -1; frame_k = 8; frame_base = 32'hC0;
`endif
    do_reset();
    f_ready = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k < 11) begin
        s_valid = 1'b1; s_data = 32'hC0 + DW'(k); s_last = (k == 2) || (k == 10);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      checks++; if (err !== (k == err_k)) begin errors++; $display("FAIL ferr_err[%0d] got=%b exp=%b", k, err, (k == err_k)); end
      checks++; if (f_valid !== (k == frame_k)) begin errors++; $display("FAIL ferr_f_valid[%0d] got=%b exp=%b", k, f_valid, (k == frame_k)); end
      if (f_valid === 1'b1) begin
        checks++;
        if (f_data !== pack_seq(frame_base)) begin
          errors++; $display("FAIL ferr_frame[%0d] got=%h exp=%h", k, f_data, pack_seq(frame_base));
        end
      end
    end
  endtask

  task automatic test_negative();
    logic [DW-1:0] vals [NP];
    logic [NP*DW-1:0] exp_f;
    vals[0] = 32'hFFFF_FFFF; vals[1] = 32'h8000_0000; vals[2] = 32'h7FFF_FFFF; vals[3] = 32'h0000_0000;
    vals[4] = 32'hFFFF_FFFE; vals[5] = 32'h8000_0001; vals[6] = 32'h1234_5678; vals[7] = 32'hDEAD_BEEF;
    for (int k = 0; k < NP; k++) exp_f[k*DW +: DW] = vals[k];
    do_reset();
    f_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = vals[k]; s_last = (k == NP - 1);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL neg_f_valid got=%b exp=1", f_valid); end
    checks++; if (f_data !== exp_f) begin errors++; $display("FAIL neg_frame got=%h exp=%h", f_data, exp_f); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; f_ready = 1'b0;
    test_reset();
    test_frame_order();
    test_backpressure();
    test_sustained();
    test_reset_mid();
    test_framing_error();
    test_negative();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
